// File: rtl/spi_bus_interface.sv
// SPI0 master peripheral on the DBus: CTRL/STATUS/TXDATA/RXDATA registers,
// SPI modes 0-3 with programmable SCLK divider and software chip select.
`timescale 1ns/1ps
module spi_bus_interface #(
  parameter int          ADDR_SEL_BITS = 18,
  parameter logic [7:0]  DIV_RESET     = 8'd3
) (
  input  logic                      i_Clk,
  input  logic                      i_nRst,
  input  logic                      i_SlaveSel,
  input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
  input  logic [3:0]                i_AV_ByteEn,
  input  logic                      i_AV_Read,
  input  logic                      i_AV_Write,
  output logic [31:0]               o_AV_ReadData,
  input  logic [31:0]               i_AV_WriteData,
  output logic                      o_AV_WaitRequest,
  output logic                      o_SPI_Clk,
  output logic                      o_SPI_nCS,
  output logic                      o_SPI_MOSI,
  input  logic                      i_SPI_MISO
);

  localparam int AW = 30 - ADDR_SEL_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] edge_q, edge_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rsh_q, rsh_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rxv_q, rxv_d;
  logic       ovr_q, ovr_d;
  logic       xcpol_q, xcpol_d;
  logic       xcpha_q, xcpha_d;
  logic [7:0] xdiv_q, xdiv_d;
  logic       cs_q, cs_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [7:0] div_q, div_d;

  logic       hit, rd_en, wr_en, busy;
  logic       tx_wr, tx_start, rx_rd;
  logic       tick, odd, last;
  logic [1:0] idx;
  logic       unused_ok;

  assign hit   = (i_RegAddr[AW-1:2] == '0);
  assign idx   = i_RegAddr[1:0];
  assign rd_en = i_SlaveSel & i_AV_Read & hit;
  assign wr_en = i_SlaveSel & i_AV_Write & hit;
  assign busy  = (state_q != S_IDLE);

  assign tx_wr    = wr_en & (idx == 2'd2) & i_AV_ByteEn[0];
  assign tx_start = tx_wr & ~busy;
  assign rx_rd    = rd_en & (idx == 2'd3);

  assign o_AV_WaitRequest = tx_wr & busy;

  // Idle SCLK follows CTRL.CPOL live; during a transfer the latched copy drives it.
  assign o_SPI_Clk  = busy ? sclk_q : cpol_q;
  assign o_SPI_nCS  = ~cs_q;
  assign o_SPI_MOSI = mosi_q;

  assign tick = (cnt_q == xdiv_q);
  assign odd  = ~edge_q[0];
  assign last = (edge_q == 4'd15);

  assign unused_ok = ^{i_AV_ByteEn[3:2], i_AV_WriteData[31:16]};

  always_comb begin
    o_AV_ReadData = '0;
    if (rd_en) begin
      case (idx)
        2'd0:    o_AV_ReadData = {16'd0, div_q, 5'd0, cpha_q, cpol_q, cs_q};
        2'd1:    o_AV_ReadData = {29'd0, ovr_q, rxv_q, busy};
        2'd3:    o_AV_ReadData = {24'd0, rxd_q};
        default: o_AV_ReadData = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rsh_d   = rsh_q;
    rxd_d   = rxd_q;
    rxv_d   = rxv_q;
    ovr_d   = ovr_q;
    xcpol_d = xcpol_q;
    xcpha_d = xcpha_q;
    xdiv_d  = xdiv_q;
    cs_d    = cs_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_d   = div_q;

    if (wr_en && idx == 2'd0) begin
      if (i_AV_ByteEn[0]) {cpha_d, cpol_d, cs_d} = i_AV_WriteData[2:0];
      if (i_AV_ByteEn[1]) div_d = i_AV_WriteData[15:8];
    end

    if (rx_rd) begin
      rxv_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (wr_en && idx == 2'd1 && i_AV_ByteEn[0] && i_AV_WriteData[2])
      ovr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          edge_d  = '0;
          xcpol_d = cpol_q;
          xcpha_d = cpha_q;
          xdiv_d  = div_q;
          sclk_d  = cpol_q;
          // CPHA=0 presents bit7 before the first edge; CPHA=1 on it.
          if (cpha_q) begin
            tx_d = i_AV_WriteData[7:0];
          end else begin
            tx_d   = {i_AV_WriteData[6:0], 1'b0};
            mosi_d = i_AV_WriteData[7];
          end
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 4'd1;
          if (xcpha_q ? ~odd : odd)
            rsh_d = {rsh_q[6:0], i_SPI_MISO};
          if (xcpha_q ? odd : (~odd & ~last)) begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (last) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rxd_d   = rsh_q;
        rxv_d   = 1'b1;
        if (rxv_q && !rx_rd) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rsh_q   <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      ovr_q   <= 1'b0;
      xcpol_q <= 1'b0;
      xcpha_q <= 1'b0;
      xdiv_q  <= DIV_RESET;
      cs_q    <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= DIV_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rsh_q   <= rsh_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      ovr_q   <= ovr_d;
      xcpol_q <= xcpol_d;
      xcpha_q <= xcpha_d;
      xdiv_q  <= xdiv_d;
      cs_q    <= cs_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
    end
  end

endmodule
